// File: rtl/ft245_fifo_bridge.sv
// FT245/UM245R host bridge: byte FIFOs, cycle-counted WR/_RD strobes, round-robin arbitration, loopback.
// Latency: flags 2-cycle synchronised; backpressure via tx_ready (TX full) and a full RX FIFO stalling device reads.
module ft245_fifo_bridge_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          mr_n,
    input  logic          push,
    input  logic [7:0]    push_dat,
    input  logic          pop,
    output logic [7:0]    head_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign level    = wr_ptr_q - rd_ptr_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!mr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

module ft245_fifo_bridge #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int RD_PULSE = 4,
    parameter int RD_GAP   = 8,
    parameter int WR_SETUP = 2,
    parameter int WR_PULSE = 3,
    parameter int WR_GAP   = 8,
    parameter int LOOPBACK = 0
) (
    input  logic                        clk,
    input  logic                        _MR,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [7:0]                  D_out,
    output logic                        D_oe,
    input  logic [7:0]                  D_in,
    output logic                        WR,
    output logic                        _RD,
    input  logic                        _TXE,
    input  logic                        _RXF
);
    localparam int CW = 8;
    localparam bit LB = (LOOPBACK != 0);
    localparam logic [CW-1:0] RD_PULSE_L = CW'(RD_PULSE - 1);
    localparam logic [CW-1:0] RD_GAP_L   = CW'(RD_GAP - 1);
    localparam logic [CW-1:0] WR_SETUP_L = CW'(WR_SETUP - 1);
    localparam logic [CW-1:0] WR_PULSE_L = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] WR_GAP_L   = CW'(WR_GAP - 1);
    localparam logic PRI_RD = 1'b0;
    localparam logic PRI_WR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_LO, ST_RD_GAP, ST_WR_SET, ST_WR_HI, ST_WR_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            prio_q, prio_d;
    logic [7:0]      d_out_q, d_out_d;
    logic            txe_meta_q, txe_meta_d, txe_s_q, txe_s_d;
    logic            rxf_meta_q, rxf_meta_d, rxf_s_q, rxf_s_d;

    logic            tx_full, tx_empty, tx_pop;
    logic [7:0]      tx_head;
    logic            rx_full, rx_empty, rx_push;
    logic [7:0]      rx_push_dat;
    logic            can_rd, can_wr;

    ft245_fifo_bridge_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .mr_n     (_MR),
        .push     (tx_valid),
        .push_dat (tx_data),
        .pop      (tx_pop),
        .head_dat (tx_head),
        .full     (tx_full),
        .empty    (tx_empty),
        .level    (tx_level)
    );

    ft245_fifo_bridge_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .mr_n     (_MR),
        .push     (rx_push),
        .push_dat (rx_push_dat),
        .pop      (rx_ready),
        .head_dat (rx_data),
        .full     (rx_full),
        .empty    (rx_empty),
        .level    (rx_level)
    );

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign can_rd   = !rxf_s_q && !rx_full;
    assign can_wr   = !txe_s_q && !tx_empty;

    always_comb begin
        txe_meta_d = _TXE;
        txe_s_d    = txe_meta_q;
        rxf_meta_d = _RXF;
        rxf_s_d    = rxf_meta_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        d_out_d     = d_out_q;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        rx_push_dat = D_in;
        unique case (state_q)
            ST_IDLE: begin
                if (LB) begin
                    if (!tx_empty && !rx_full) begin
                        tx_pop      = 1'b1;
                        rx_push     = 1'b1;
                        rx_push_dat = tx_head;
                    end
                end else if (can_rd && (!can_wr || prio_q == PRI_RD)) begin
                    state_d = ST_RD_LO;
                    cnt_d   = RD_PULSE_L;
                    prio_d  = PRI_WR;
                end else if (can_wr) begin
                    state_d = ST_WR_SET;
                    cnt_d   = WR_SETUP_L;
                    prio_d  = PRI_RD;
                    tx_pop  = 1'b1;
                    d_out_d = tx_head;
                end
            end
            ST_RD_LO: begin
                if (cnt_q == '0) begin
                    rx_push = 1'b1;
                    state_d = ST_RD_GAP;
                    cnt_d   = RD_GAP_L;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RD_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_WR_SET: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_HI;
                    cnt_d   = WR_PULSE_L;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR_HI: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_GAP;
                    cnt_d   = WR_GAP_L;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decode straight from the state flop so reset drops them on the reset edge.
    assign WR    = (state_q == ST_WR_HI);
    assign _RD   = (state_q != ST_RD_LO);
    assign D_oe  = (state_q == ST_WR_SET) || (state_q == ST_WR_HI) ||
                   ((state_q == ST_WR_GAP) && (cnt_q == WR_GAP_L));
    assign D_out = d_out_q;

    always_ff @(posedge clk) begin
        if (!_MR) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            prio_q     <= PRI_RD;
            d_out_q    <= '0;
            txe_meta_q <= 1'b1;
            txe_s_q    <= 1'b1;
            rxf_meta_q <= 1'b1;
            rxf_s_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            d_out_q    <= d_out_d;
            txe_meta_q <= txe_meta_d;
            txe_s_q    <= txe_s_d;
            rxf_meta_q <= rxf_meta_d;
            rxf_s_q    <= rxf_s_d;
        end
    end
endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Directed bench for ft245_fifo_bridge: reset, TX/RX strobes, RX-full stall, contention, loopback.
module tb_ft245_fifo_bridge;
    logic       clk = 1'b0;
    logic       mr_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [4:0] tx_level;
    logic [2:0] rx_level;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] d_in = 8'h00;
    logic       wr;
    logic       rd_n;
    logic       txe_n = 1'b1;
    logic       rxf_n = 1'b1;

    logic [7:0] lb_tx_data = 8'h00;
    logic       lb_tx_valid = 1'b0;
    logic       lb_tx_ready;
    logic [7:0] lb_rx_data;
    logic       lb_rx_valid;
    logic [4:0] lb_tx_level;
    logic [4:0] lb_rx_level;
    logic [7:0] lb_d_out;
    logic       lb_d_oe;
    logic       lb_wr;
    logic       lb_rd_n;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ft245_fifo_bridge #(.TX_DEPTH(16), .RX_DEPTH(4), .LOOPBACK(0)) dut (
        .clk(clk), ._MR(mr_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level),
        .D_out(d_out), .D_oe(d_oe), .D_in(d_in),
        .WR(wr), ._RD(rd_n), ._TXE(txe_n), ._RXF(rxf_n)
    );

    ft245_fifo_bridge #(.TX_DEPTH(16), .RX_DEPTH(16), .LOOPBACK(1)) dut_lb (
        .clk(clk), ._MR(mr_n),
        .tx_data(lb_tx_data), .tx_valid(lb_tx_valid), .tx_ready(lb_tx_ready),
        .rx_data(lb_rx_data), .rx_valid(lb_rx_valid), .rx_ready(1'b1),
        .tx_level(lb_tx_level), .rx_level(lb_rx_level),
        .D_out(lb_d_out), .D_oe(lb_d_oe), .D_in(8'hA5),
        .WR(lb_wr), ._RD(lb_rd_n), ._TXE(1'b0), ._RXF(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Strobe monitor: overlap violations, strobe-start order (1 = WR, 0 = RD), RD start count.
    int   overlap_cnt = 0;
    int   rd_starts   = 0;
    int   lb_pin_act  = 0;
    logic prev_wr_m   = 1'b0;
    logic prev_rd_m   = 1'b1;
    logic seq_q [$];

    always @(negedge clk) begin
        if (wr && !rd_n) overlap_cnt++;
        if (d_oe && !rd_n) overlap_cnt++;
        if (lb_wr || !lb_rd_n || lb_d_oe) lb_pin_act++;
        if (wr && !prev_wr_m) seq_q.push_back(1'b1);
        if (!rd_n && prev_rd_m) begin
            seq_q.push_back(1'b0);
            rd_starts++;
        end
        prev_wr_m = wr;
        prev_rd_m = rd_n;
    end

    task automatic push_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int g = 0; g < 40 && !tx_ready; g++) @(negedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    logic [7:0] exp_b [2];
    int  seen, lo, base, n_wr, n_oe, hi, oe_rise_c, wr_fall_c, last_rise, n_got;
    logic prev_wr, prev_oe, stable;
    logic [7:0] latched;

    initial begin
        exp_b[0] = 8'h41;
        exp_b[1] = 8'h42;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr", wr, 1'b0);
        check("rst_rd_n", rd_n, 1'b1);
        check("rst_d_oe", d_oe, 1'b0);
        check("rst_d_out", d_out, 8'h00);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_levels", {tx_level, rx_level}, '0);
        mr_n = 1'b1;

        // Test 1: reset asserted while WR is high, with one byte still queued
        txe_n = 1'b0;
        push_tx(8'h99);
        push_tx(8'h98);
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            @(negedge clk);
            if (wr) seen = 1;
        end
        check("t1_wr_seen", seen, 1);
        check("t1_tx_level_before", tx_level, 5'd1);
        mr_n = 1'b0;
        @(negedge clk);
        check("t1_wr", wr, 1'b0);
        check("t1_d_oe", d_oe, 1'b0);
        check("t1_rd_n", rd_n, 1'b1);
        check("t1_tx_level", tx_level, 5'd0);
        check("t1_rx_level", rx_level, 3'd0);
        check("t1_tx_ready", tx_ready, 1'b1);
        mr_n  = 1'b1;
        txe_n = 1'b1;
        repeat (3) @(negedge clk);

        // Test 2: two writes, pulse width, setup, period, D_out stability
        push_tx(8'h41);
        push_tx(8'h42);
        check("t2_tx_level", tx_level, 5'd2);
        txe_n = 1'b0;
        prev_wr = 1'b0; prev_oe = 1'b0; stable = 1'b1; latched = 8'h00;
        n_wr = 0; n_oe = 0; hi = 0; oe_rise_c = 0; wr_fall_c = 0; last_rise = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (d_oe && !prev_oe) begin
                if (n_oe < 2) check("t2_d_out_byte", d_out, exp_b[n_oe]);
                latched = d_out; stable = 1'b1; oe_rise_c = c; n_oe++;
            end
            if (d_oe && d_out != latched) stable = 1'b0;
            if (wr && !prev_wr) begin
                check("t2_wr_setup", c - oe_rise_c, 2);
                if (n_wr > 0) check("t2_wr_period", c - last_rise, 14);
                last_rise = c; hi = 0;
            end
            if (wr) hi++;
            if (!wr && prev_wr) begin
                check("t2_wr_width", hi, 3);
                check("t2_oe_hold", d_oe, 1'b1);
                wr_fall_c = c; n_wr++;
            end
            if (!d_oe && prev_oe) begin
                check("t2_d_out_stable", stable, 1'b1);
                check("t2_oe_drop", c - wr_fall_c, 1);
            end
            prev_wr = wr; prev_oe = d_oe;
        end
        check("t2_wr_count", n_wr, 2);
        check("t2_tx_empty", tx_level, 5'd0);
        txe_n = 1'b1;

        // Test 3: single device read
        d_in  = 8'h5A;
        rxf_n = 1'b0;
        seen = 0;
        for (int c = 0; c < 30 && seen == 0; c++) begin
            @(negedge clk);
            if (!rd_n) seen = 1;
        end
        check("t3_rd_seen", seen, 1);
        rxf_n = 1'b1;
        lo = 0;
        while (!rd_n && lo < 20) begin
            lo++;
            @(negedge clk);
        end
        check("t3_rd_width", lo, 4);
        check("t3_rx_valid", rx_valid, 1'b1);
        check("t3_rx_data", rx_data, 8'h5A);
        check("t3_rx_level", rx_level, 3'd1);
        pop_rx();
        check("t3_rx_level_pop", rx_level, 3'd0);

        // Test 4: RX FIFO (depth 4) fills, reads stop, one pop lets exactly one more read
        d_in  = 8'h33;
        base  = rd_starts;
        rxf_n = 1'b0;
        repeat (100) @(negedge clk);
        check("t4_read_count", rd_starts - base, 4);
        check("t4_rx_level_full", rx_level, 3'd4);
        check("t4_rx_data", rx_data, 8'h33);
        check("t4_rd_idle", rd_n, 1'b1);
        pop_rx();
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (!rd_n) seen = 1;
        end
        check("t4_read_resumes", seen, 1);
        rxf_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t4_rx_level_refill", rx_level, 3'd4);
        @(negedge clk);
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        rx_ready = 1'b0;
        check("t4_rx_drained", rx_level, 3'd0);

        // Test 5: contention; last transfer was a read, so the write side goes first
        push_tx(8'hC1);
        push_tx(8'hC2);
        push_tx(8'hC3);
        repeat (2) @(negedge clk);
        seq_q.delete();
        rx_ready = 1'b1;
        txe_n    = 1'b0;
        rxf_n    = 1'b0;
        repeat (70) @(negedge clk);
        txe_n = 1'b1;
        rxf_n = 1'b1;
        check("t5_strobe_count_ge4", seq_q.size() >= 4, 1'b1);
        if (seq_q.size() >= 4) begin
            check("t5_seq0_wr", seq_q[0], 1'b1);
            check("t5_seq1_rd", seq_q[1], 1'b0);
            check("t5_seq2_wr", seq_q[2], 1'b1);
            check("t5_seq3_rd", seq_q[3], 1'b0);
        end
        repeat (20) @(negedge clk);
        rx_ready = 1'b0;
        check("t5_no_overlap", overlap_cnt, 0);

        // Test 6: loopback, 20 bytes back-to-back so the TX index wraps past entry 16
        n_got = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    lb_tx_data  = 8'(i);
                    lb_tx_valid = 1'b1;
                    for (int g = 0; g < 40 && !lb_tx_ready; g++) @(negedge clk);
                end
                @(negedge clk);
                lb_tx_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (lb_rx_valid) begin
                        if (n_got < 20) check("t6_lb_byte", lb_rx_data, 8'(n_got));
                        n_got++;
                    end
                end
            end
        join
        check("t6_lb_count", n_got, 20);
        check("t6_lb_levels", {lb_tx_level, lb_rx_level}, '0);
        check("t6_lb_pins_idle", lb_pin_act, 0);
        check("t6_lb_d_out", lb_d_out, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
